// File: rtl/lr_sc_reservation_unit_pkg.sv
// Shared definitions for the LR/SC reservation unit: FSM state encoding,
// reservation granule and SC result encodings.
package lr_sc_reservation_unit_pkg;

  typedef logic [1:0] resv_state_t;

  localparam resv_state_t ST_IDLE    = 2'd0;
  localparam resv_state_t ST_HELD    = 2'd1;
  localparam resv_state_t ST_SC_RESP = 2'd2;

  // Reservations cover one aligned 32-bit word.
  localparam int RESV_GRANULE_LSB = 2;

  // Value written to rd by SC.W.
  localparam logic SC_SUCCESS = 1'b0;
  localparam logic SC_FAILURE = 1'b1;

endpackage

// File: rtl/lr_sc_reservation_unit_resv_timeout_ctr.sv
// Reservation lifetime counter. Reloads on LR, counts down while a
// reservation is held and reports expiry when it reaches zero.
// Only instantiated when LRSC_TIMEOUT_EN is defined.
module resv_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Reload on a new reservation, otherwise count down to zero while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt <= '0;
    else if (load)                   cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
    else if (run && (cnt != '0))     cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/lr_sc_reservation_unit.sv
// LR/SC reservation tracker for a single hart. Holds at most one word
// reservation, grants SC writes combinationally and returns the SC result
// as a registered one-cycle pulse.
// Optional feature: define LRSC_TIMEOUT_EN to bound reservation lifetime
// to TIMEOUT_CYCLES cycles.
module lr_sc_reservation_unit
  import lr_sc_reservation_unit_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lr_valid,
  input  logic              sc_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              store_valid,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic              flush,
  output logic              reserved,
  output logic [ADDR_W-1:0] reserved_addr,
  output logic              sc_write_en,
  output logic              sc_done,
  output logic              sc_fail
);

  localparam int W = RESV_GRANULE_LSB;

  resv_state_t state, state_nxt;
  logic        lr_take;
  logic        mem_match;
  logic        st_conflict;
  logic        expired;

  assign reserved    = (state == ST_HELD);
  assign mem_match   = (mem_addr[ADDR_W-1:W] == reserved_addr[ADDR_W-1:W]);
  assign st_conflict = reserved & store_valid &
                       (store_addr[ADDR_W-1:W] == reserved_addr[ADDR_W-1:W]);
  // An LR only takes effect when neither a flush nor an SC outranks it.
  assign lr_take     = lr_valid & ~sc_valid & ~flush;

`ifdef LRSC_TIMEOUT_EN
  logic expired_raw;

  resv_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (lr_take),
    .run    (reserved),
    .expired(expired_raw)
  );

  assign expired = reserved & expired_raw;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif

  // A same-cycle store to the reserved word or an expiring reservation
  // kills the SC before it can write.
  assign sc_write_en = sc_valid & reserved & mem_match & ~flush &
                       ~st_conflict & ~expired;

  // Next-state: flush > SC > LR > store/timeout.
  always_comb begin
    state_nxt = ST_IDLE;
    if (flush)                                state_nxt = ST_IDLE;
    else if (sc_valid)                        state_nxt = ST_SC_RESP;
    else if (lr_valid)                        state_nxt = ST_HELD;
    else if (state == ST_HELD && !expired && !st_conflict)
                                              state_nxt = ST_HELD;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Latch the word-aligned reservation address on an accepted LR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       reserved_addr <= '0;
    else if (lr_take) reserved_addr <= {mem_addr[ADDR_W-1:W], {W{1'b0}}};
  end

  // SC result pulse, one cycle after the SC; flush still reports a failure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_done <= 1'b0;
      sc_fail <= 1'b0;
    end else begin
      sc_done <= sc_valid;
      sc_fail <= sc_valid ? (sc_write_en ? SC_SUCCESS : SC_FAILURE) : 1'b0;
    end
  end

endmodule
